// File: rtl/signed_data_pkg.sv
// Shared types for the signed/unsigned sample narrowing pipeline.
// The stage-register struct is sized from L_WD_DEF; override both together.
package signed_data_pkg;

  localparam int SAT_CNT_WD = 16;
  localparam int L_WD_DEF   = 24;
  localparam int S_WD_DEF   = 16;
  localparam int VAL_WD     = L_WD_DEF + 1;

  typedef logic [SAT_CNT_WD-1:0] sat_cnt_t;

  typedef struct packed {
    logic [VAL_WD-1:0] data;
    logic              is_signed;
    logic              vld;
  } stage_t;

endpackage

// File: rtl/signed_data_sat.sv
// Combinational saturator: clamps a VAL_WD-bit value to S_WD bits, signed or unsigned.
module signed_data_sat #(
  parameter int VAL_WD = 25,
  parameter int S_WD   = 16
) (
  input  logic [VAL_WD-1:0] value,
  input  logic              is_signed,
  output logic [S_WD-1:0]   data,
  output logic              sat
);

  // NOTE: every output gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    data = value[S_WD-1:0];
    sat  = 1'b0;
    if (is_signed) begin
      // In range only when all bits from the S_WD sign bit upward agree.
      if (!(&value[VAL_WD-1:S_WD-1] || ~|value[VAL_WD-1:S_WD-1])) begin
        sat  = 1'b1;
        data = {value[VAL_WD-1], {(S_WD-1){~value[VAL_WD-1]}}};
      end
    end else if (|value[VAL_WD-1:S_WD]) begin
      sat  = 1'b1;
      data = '1;
    end
  end

endmodule

// File: rtl/signed_data_narrow.sv
// Two-stage valid/ready narrowing pipeline (shift, then saturate) with a saturation counter.
// Optional rounding before the shift: define SIGNED_DATA_NARROW_ROUND_EN.
module signed_data_narrow
  import signed_data_pkg::*;
#(
  parameter int L_WD  = L_WD_DEF,
  parameter int S_WD  = S_WD_DEF,
  parameter int SHIFT = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [L_WD-1:0]       data_i,
  input  logic                  signed_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [S_WD-1:0]       data_o,
  output logic                  sat_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  input  logic                  clr_cnt_i,
  output logic [SAT_CNT_WD-1:0] sat_cnt_o
);

  stage_t          s1;
  logic [L_WD:0]   ext;
  logic [L_WD:0]   rnd;
  logic [L_WD:0]   shifted;
  logic [S_WD-1:0] sat_data;
  logic            sat_flag;
  logic            adv1;
  logic            adv2;

  assign adv2    = !valid_o || ready_i;
  assign adv1    = !s1.vld || adv2;
  assign ready_o = adv1;

  assign ext = {signed_i & data_i[L_WD-1], data_i};

`ifdef SIGNED_DATA_NARROW_ROUND_EN
  if (SHIFT > 0) begin : g_round
    localparam logic [L_WD:0] HALF = (L_WD+1)'(1) << (SHIFT - 1);
    // Wraps in L_WD+1 bits; a rounding carry out of range is caught by the saturator.
    assign rnd = ext + HALF;
  end else begin : g_no_round
    assign rnd = ext;
  end
`else
  assign rnd = ext;
`endif

  always_comb begin
    if (signed_i) shifted = $unsigned($signed(rnd) >>> SHIFT);
    else          shifted = rnd >> SHIFT;
  end

  // NOTE: sequential state uses non-blocking assignments so both stages see pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1 <= '0;
    end else if (adv1) begin
      s1.vld       <= valid_i;
      s1.data      <= shifted;
      s1.is_signed <= signed_i;
    end
  end

  signed_data_sat #(
    .VAL_WD (L_WD + 1),
    .S_WD   (S_WD)
  ) u_sat (
    .value     (s1.data),
    .is_signed (s1.is_signed),
    .data      (sat_data),
    .sat       (sat_flag)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      sat_o   <= 1'b0;
    end else if (adv2) begin
      valid_o <= s1.vld;
      data_o  <= sat_data;
      sat_o   <= sat_flag;
    end
  end

  // Clear has priority; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sat_cnt_o <= '0;
    end else if (clr_cnt_i) begin
      sat_cnt_o <= '0;
    end else if (valid_o && ready_i && sat_o && (sat_cnt_o != '1)) begin
      sat_cnt_o <= sat_cnt_o + 1'b1;
    end
  end

endmodule
